wb_arbiter: RTL and testbench
=============================

// Module: wb_arbiter
// PURPOSE
//  Two-master, one-slave Wishbone arbiter on the CPU side of the SoC bus.
//  Master 1 is the CPU bus interface unit (it consumes m1_gnt_o as wb_m1_cpu_gnt).
//  Master 0 is the DMA/video fetch port.
//  Round-robin grant; one owner per bus cycle. A watchdog ends hung cycles with an error.
// PARAMETERS
//  TIMEOUT  255  cycles stb may wait unterminated before an error is forced (>=2)
//  TO_W     8    width of the watchdog counter; must hold TIMEOUT
// PORTS
//  clk         in   1   system clock, all state on rising edge
//  rst         in   1   synchronous reset, active high
//  mN_cyc_i    in   1   master N (N=0,1) cycle request
//  mN_stb_i    in   1   master N strobe
//  mN_we_i     in   1   master N write enable
//  mN_adr_i    in   32  master N address
//  mN_sel_i    in   4   master N byte selects
//  mN_dat_i    in   32  master N write data
//  mN_dat_o    out  32  read data to master N (= s_dat_i, unconditionally)
//  mN_ack_o    out  1   ack to master N
//  mN_err_o    out  1   error to master N (slave err or watchdog)
//  mN_rty_o    out  1   retry to master N
//  mN_gnt_o    out  1   master N owns the bus (registered)
//  s_cyc_o     out  1   slave cycle
//  s_stb_o     out  1   slave strobe
//  s_we_o      out  1   slave write enable
//  s_adr_o     out  32  slave address
//  s_sel_o     out  4   slave byte selects
//  s_dat_o     out  32  slave write data
//  s_dat_i     in   32  slave read data
//  s_ack_i     in   1   slave ack
//  s_err_i     in   1   slave error
//  s_rty_i     in   1   slave retry
// BEHAVIOUR
//  - Reset (rst=1 at edge):
//    - state=IDLE, last=1, cnt=0.
//    - gnt_o=0; s_cyc_o/s_stb_o/s_we_o=0; ack/err/rty outputs=0.
//    - Reset mid-transfer aborts the cycle; any late ack is ignored.
//  - FSM states: IDLE, OWN0, OWN1.
//  - IDLE:
//    - Only m0_cyc_i -> OWN0. Only m1_cyc_i -> OWN1.
//    - Both requesting -> grant the master != last.
//    - Grant is visible one cycle after cyc_i is sampled.
//  - OWNn:
//    - Slave outputs are muxed from master n.
//    - s_cyc_o = mn_cyc_i; s_stb_o = mn_stb_i & ~to_hit.
//    - In IDLE, s_* outputs are 0 and adr/sel/dat are don't-care.
//  - Termination routing:
//    - mn_ack_o = s_ack_i, mn_rty_o = s_rty_i, mn_err_o = s_err_i | to_hit (combinational).
//    - The non-owner's ack/err/rty are always 0.
//  - Release:
//    - Owner drops cyc_i -> IDLE next cycle, last <= n.
//    - There is always at least one IDLE cycle between owners.
//    - A single master may re-win after that IDLE cycle.
//  - Watchdog:
//    - cnt increments each owned cycle where stb_i=1 and s_ack_i|s_err_i|s_rty_i=0.
//    - cnt clears on any termination, on stb_i=0, and in IDLE.
//    - to_hit = (cnt==TIMEOUT). In the to_hit cycle: mn_err_o=1, s_stb_o=0, cnt clears.
//    - If the slave ack arrives in the to_hit cycle, ack is forwarded and err is suppressed.
//  - Owner drops cyc_i with stb pending: the transfer is abandoned, no ack/err is generated.
//  - Slave ack/err/rty while IDLE: discarded.
// TESTING
//  1. Reset, then m1 cyc/stb/we=0, adr=0x3000_0010:
//     - m1_gnt_o=1 next cycle; s_adr_o=0x3000_0010.
//     - s_ack_i with s_dat_i=0xDEADBEEF -> m1_ack_o=1, m1_dat_o=0xDEADBEEF same cycle.
//  2. Both masters raise cyc at the same edge after reset:
//     - m0 granted first.
//     - m0 drops cyc -> one IDLE cycle -> m1_gnt_o=1.
//  3. Both masters request continuously, each releasing after one ack:
//     - Grants alternate 0,1,0,1; m0_gnt_o and m1_gnt_o are never high together.
//  4. TIMEOUT=8, m0 stb held, slave silent:
//     - m0_err_o=1 for exactly one cycle on the 9th stb cycle, s_stb_o=0 that cycle.
//     - cnt restarts from 0 afterwards.
//  5. TIMEOUT=8, slave ack in the to_hit cycle -> m0_ack_o=1, m0_err_o=0.
//  6. rst pulsed mid-transfer while m1 is owner:
//     - Next cycle m1_gnt_o=0, s_cyc_o=0.
//     - A later s_ack_i produces no m1_ack_o.

Source files
------------

// File: rtl/wb_arbiter.sv
// Two-master, one-slave Wishbone arbiter with round-robin grant and a watchdog
// that forces an error on strobes the slave leaves unterminated for too long.
module wb_arbiter #(
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned TO_W    = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        m0_cyc_i,
  input  logic        m0_stb_i,
  input  logic        m0_we_i,
  input  logic [31:0] m0_adr_i,
  input  logic [3:0]  m0_sel_i,
  input  logic [31:0] m0_dat_i,
  output logic [31:0] m0_dat_o,
  output logic        m0_ack_o,
  output logic        m0_err_o,
  output logic        m0_rty_o,
  output logic        m0_gnt_o,
  input  logic        m1_cyc_i,
  input  logic        m1_stb_i,
  input  logic        m1_we_i,
  input  logic [31:0] m1_adr_i,
  input  logic [3:0]  m1_sel_i,
  input  logic [31:0] m1_dat_i,
  output logic [31:0] m1_dat_o,
  output logic        m1_ack_o,
  output logic        m1_err_o,
  output logic        m1_rty_o,
  output logic        m1_gnt_o,
  output logic        s_cyc_o,
  output logic        s_stb_o,
  output logic        s_we_o,
  output logic [31:0] s_adr_o,
  output logic [3:0]  s_sel_o,
  output logic [31:0] s_dat_o,
  input  logic [31:0] s_dat_i,
  input  logic        s_ack_i,
  input  logic        s_err_i,
  input  logic        s_rty_i
);

  typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

  state_t            r_state;
  logic              r_last;
  logic              r_gnt0;
  logic              r_gnt1;
  logic [TO_W-1:0]   r_cnt;

  logic w_own0;
  logic w_own1;
  logic w_cyc;
  logic w_stb;
  logic w_term;
  logic w_to_hit;

  assign w_own0   = (r_state == OWN0);
  assign w_own1   = (r_state == OWN1);
  assign w_cyc    = (w_own0 & m0_cyc_i) | (w_own1 & m1_cyc_i);
  assign w_stb    = w_cyc & ((w_own0 & m0_stb_i) | (w_own1 & m1_stb_i));
  assign w_term   = s_ack_i | s_err_i | s_rty_i;
  assign w_to_hit = w_stb & (r_cnt == TO_W'(TIMEOUT));

  // Ownership FSM; grants are registered alongside the state.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_last  <= 1'b1;
      r_gnt0  <= 1'b0;
      r_gnt1  <= 1'b0;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          r_cnt <= '0;
          if (m0_cyc_i && (!m1_cyc_i || r_last)) begin
            r_state <= OWN0;
            r_gnt0  <= 1'b1;
          end else if (m1_cyc_i) begin
            r_state <= OWN1;
            r_gnt1  <= 1'b1;
          end
        end
        OWN0, OWN1: begin
          if (!w_cyc) begin
            r_state <= IDLE;
            r_last  <= w_own1;
            r_gnt0  <= 1'b0;
            r_gnt1  <= 1'b0;
            r_cnt   <= '0;
          end else if (!w_stb || w_term || w_to_hit) begin
            r_cnt <= '0;
          end else begin
            r_cnt <= r_cnt + TO_W'(1);
          end
        end
        default: begin
          r_state <= IDLE;
          r_gnt0  <= 1'b0;
          r_gnt1  <= 1'b0;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  // Slave-side mux and termination routing to the current owner only.
  always_comb begin
    s_cyc_o  = w_cyc;
    s_stb_o  = w_stb & ~w_to_hit;
    s_we_o   = w_cyc & (w_own1 ? m1_we_i : m0_we_i);
    s_adr_o  = w_own1 ? m1_adr_i : m0_adr_i;
    s_sel_o  = w_own1 ? m1_sel_i : m0_sel_i;
    s_dat_o  = w_own1 ? m1_dat_i : m0_dat_i;
    m0_ack_o = w_own0 & w_cyc & s_ack_i;
    m0_rty_o = w_own0 & w_cyc & s_rty_i;
    m0_err_o = w_own0 & w_cyc & (s_err_i | (w_to_hit & ~s_ack_i));
    m1_ack_o = w_own1 & w_cyc & s_ack_i;
    m1_rty_o = w_own1 & w_cyc & s_rty_i;
    m1_err_o = w_own1 & w_cyc & (s_err_i | (w_to_hit & ~s_ack_i));
  end

  assign m0_dat_o = s_dat_i;
  assign m1_dat_o = s_dat_i;
  assign m0_gnt_o = r_gnt0;
  assign m1_gnt_o = r_gnt1;

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter built with a short watchdog (TIMEOUT=8).
module tb_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        m0_cyc_i, m0_stb_i, m0_we_i;
  logic [31:0] m0_adr_i, m0_dat_i, m0_dat_o;
  logic [3:0]  m0_sel_i;
  logic        m0_ack_o, m0_err_o, m0_rty_o, m0_gnt_o;
  logic        m1_cyc_i, m1_stb_i, m1_we_i;
  logic [31:0] m1_adr_i, m1_dat_i, m1_dat_o;
  logic [3:0]  m1_sel_i;
  logic        m1_ack_o, m1_err_o, m1_rty_o, m1_gnt_o;
  logic        s_cyc_o, s_stb_o, s_we_o;
  logic [31:0] s_adr_o, s_dat_o, s_dat_i;
  logic [3:0]  s_sel_o;
  logic        s_ack_i, s_err_i, s_rty_i;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  wb_arbiter #(.TIMEOUT(8), .TO_W(8)) dut (
    .clk(clk), .rst(rst),
    .m0_cyc_i(m0_cyc_i), .m0_stb_i(m0_stb_i), .m0_we_i(m0_we_i),
    .m0_adr_i(m0_adr_i), .m0_sel_i(m0_sel_i), .m0_dat_i(m0_dat_i),
    .m0_dat_o(m0_dat_o), .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o),
    .m0_rty_o(m0_rty_o), .m0_gnt_o(m0_gnt_o),
    .m1_cyc_i(m1_cyc_i), .m1_stb_i(m1_stb_i), .m1_we_i(m1_we_i),
    .m1_adr_i(m1_adr_i), .m1_sel_i(m1_sel_i), .m1_dat_i(m1_dat_i),
    .m1_dat_o(m1_dat_o), .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o),
    .m1_rty_o(m1_rty_o), .m1_gnt_o(m1_gnt_o),
    .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o),
    .s_adr_o(s_adr_o), .s_sel_o(s_sel_o), .s_dat_o(s_dat_o),
    .s_dat_i(s_dat_i), .s_ack_i(s_ack_i), .s_err_i(s_err_i), .s_rty_i(s_rty_i)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    logic exp_m1;
    rst = 1'b1;
    {m0_cyc_i, m0_stb_i, m0_we_i, m1_cyc_i, m1_stb_i, m1_we_i} = '0;
    m0_adr_i = '0; m0_sel_i = 4'hF; m0_dat_i = 32'h1111_1111;
    m1_adr_i = '0; m1_sel_i = 4'hF; m1_dat_i = 32'h2222_2222;
    s_dat_i = '0; {s_ack_i, s_err_i, s_rty_i} = '0;
    tick(); tick();
    rst = 1'b0;
    #1;
    chk("rst_m0_gnt", 32'(m0_gnt_o), 32'd0);
    chk("rst_m1_gnt", 32'(m1_gnt_o), 32'd0);
    chk("rst_s_cyc", 32'(s_cyc_o), 32'd0);
    chk("rst_s_stb", 32'(s_stb_o), 32'd0);

    // Single CPU read
    m1_cyc_i = 1'b1; m1_stb_i = 1'b1; m1_we_i = 1'b0; m1_adr_i = 32'h3000_0010;
    tick();
    chk("t1_m1_gnt", 32'(m1_gnt_o), 32'd1);
    chk("t1_m0_gnt", 32'(m0_gnt_o), 32'd0);
    chk("t1_s_adr", s_adr_o, 32'h3000_0010);
    chk("t1_s_stb", 32'(s_stb_o), 32'd1);
    chk("t1_s_we", 32'(s_we_o), 32'd0);
    s_ack_i = 1'b1; s_dat_i = 32'hDEAD_BEEF;
    #1;
    chk("t1_m1_ack", 32'(m1_ack_o), 32'd1);
    chk("t1_m1_dat", m1_dat_o, 32'hDEAD_BEEF);
    chk("t1_m0_ack", 32'(m0_ack_o), 32'd0);
    tick();
    s_ack_i = 1'b0; m1_cyc_i = 1'b0; m1_stb_i = 1'b0;
    tick();
    chk("t1_release", 32'(m1_gnt_o), 32'd0);

    // Simultaneous request: m0 first, then m1 after one idle cycle
    m0_cyc_i = 1'b1; m0_stb_i = 1'b1; m0_adr_i = 32'h0000_0100;
    m1_cyc_i = 1'b1; m1_stb_i = 1'b1; m1_adr_i = 32'h0000_0200;
    tick();
    chk("t2_m0_gnt", 32'(m0_gnt_o), 32'd1);
    chk("t2_m1_gnt", 32'(m1_gnt_o), 32'd0);
    chk("t2_s_adr", s_adr_o, 32'h0000_0100);
    m0_cyc_i = 1'b0; m0_stb_i = 1'b0;
    #1;
    chk("t2_drop_s_cyc", 32'(s_cyc_o), 32'd0);
    tick();
    chk("t2_idle_m0", 32'(m0_gnt_o), 32'd0);
    chk("t2_idle_m1", 32'(m1_gnt_o), 32'd0);
    s_ack_i = 1'b1;
    #1;
    chk("t2_idle_ack1", 32'(m1_ack_o), 32'd0);
    chk("t2_idle_ack0", 32'(m0_ack_o), 32'd0);
    s_ack_i = 1'b0;
    tick();
    chk("t2_m1_gnt", 32'(m1_gnt_o), 32'd1);
    chk("t2_m1_adr", s_adr_o, 32'h0000_0200);
    s_ack_i = 1'b1;
    #1;
    chk("t2_m1_ack", 32'(m1_ack_o), 32'd1);
    tick();
    s_ack_i = 1'b0; m1_cyc_i = 1'b0; m1_stb_i = 1'b0;
    tick();

    // Continuous contention: grants alternate 0,1,0,1
    for (int k = 0; k < 4; k++) begin
      exp_m1 = (k % 2) == 1;
      m0_cyc_i = 1'b1; m0_stb_i = 1'b1; m1_cyc_i = 1'b1; m1_stb_i = 1'b1;
      tick();
      chk($sformatf("t3_m0_gnt_%0d", k), 32'(m0_gnt_o), 32'(!exp_m1));
      chk($sformatf("t3_m1_gnt_%0d", k), 32'(m1_gnt_o), 32'(exp_m1));
      chk($sformatf("t3_excl_%0d", k), 32'(m0_gnt_o & m1_gnt_o), 32'd0);
      s_ack_i = 1'b1;
      #1;
      chk($sformatf("t3_ack_%0d", k), 32'(exp_m1 ? m1_ack_o : m0_ack_o), 32'd1);
      chk($sformatf("t3_noack_%0d", k), 32'(exp_m1 ? m0_ack_o : m1_ack_o), 32'd0);
      tick();
      s_ack_i = 1'b0;
      if (exp_m1) begin m1_cyc_i = 1'b0; m1_stb_i = 1'b0; end
      else        begin m0_cyc_i = 1'b0; m0_stb_i = 1'b0; end
      tick();
      chk($sformatf("t3_gap_%0d", k), 32'({m0_gnt_o, m1_gnt_o}), 32'd0);
    end
    {m0_cyc_i, m0_stb_i, m1_cyc_i, m1_stb_i} = '0;
    tick();

    // Watchdog: silent slave, error on 9th strobe cycle
    m0_cyc_i = 1'b1; m0_stb_i = 1'b1;
    tick();
    chk("t4_m0_gnt", 32'(m0_gnt_o), 32'd1);
    for (int i = 1; i <= 8; i++) begin
      chk($sformatf("t4_noerr_%0d", i), 32'(m0_err_o), 32'd0);
      chk($sformatf("t4_stb_%0d", i), 32'(s_stb_o), 32'd1);
      tick();
    end
    chk("t4_err", 32'(m0_err_o), 32'd1);
    chk("t4_stb_kill", 32'(s_stb_o), 32'd0);
    chk("t4_m1_err", 32'(m1_err_o), 32'd0);
    tick();
    chk("t4_after_err", 32'(m0_err_o), 32'd0);
    chk("t4_after_stb", 32'(s_stb_o), 32'd1);
    for (int i = 0; i < 7; i++) tick();
    chk("t4_restart_noerr", 32'(m0_err_o), 32'd0);
    tick();
    // Slave ack lands exactly in the timeout cycle
    chk("t5_stb_kill", 32'(s_stb_o), 32'd0);
    s_ack_i = 1'b1;
    #1;
    chk("t5_ack", 32'(m0_ack_o), 32'd1);
    chk("t5_err", 32'(m0_err_o), 32'd0);
    tick();
    s_ack_i = 1'b0; m0_cyc_i = 1'b0; m0_stb_i = 1'b0;
    tick();

    // Reset while m1 owns the bus
    m1_cyc_i = 1'b1; m1_stb_i = 1'b1;
    tick();
    chk("t6_m1_gnt", 32'(m1_gnt_o), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t6_gnt_rst", 32'(m1_gnt_o), 32'd0);
    chk("t6_s_cyc", 32'(s_cyc_o), 32'd0);
    s_ack_i = 1'b1;
    #1;
    chk("t6_late_ack", 32'(m1_ack_o), 32'd0);
    m1_cyc_i = 1'b0; m1_stb_i = 1'b0;
    tick();
    chk("t6_late_ack2", 32'(m1_ack_o), 32'd0);
    chk("t6_gnt_idle", 32'(m1_gnt_o), 32'd0);
    s_ack_i = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
